// File: rtl/keycode_player.sv
// rtl/keycode_player.sv - scripted keyboard player: FIFO of keycodes replayed as timed press/release pairs
// Each popped keycode is driven for HOLD_CYCLES, then released to 8'h00 for GAP_CYCLES.

module keycode_player #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push_valid,
  input  logic [7:0]               push_keycode,
  output logic                     push_ready,
  input  logic                     abort,
  output logic [7:0]               keycode,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign push_ready = (fifo_count < DEPTH_C) && !abort;
  assign push       = push_valid && push_ready;
  // A pop happens only when the player is ready for the next key; RELEASE chains straight into PRESS.
  assign pop        = !abort && (fifo_count != '0) &&
                      ((state == IDLE) || ((state == RELEASE) && (cnt == 8'd0)));

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= push_keycode;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      keycode <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      keycode <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          keycode <= 8'h00;
          busy    <= 1'b0;
          if (pop) begin
            keycode <= mem[rd_ptr];
            cnt     <= HOLD_LOAD;
            busy    <= 1'b1;
            state   <= PRESS;
          end
        end
        PRESS: begin
          if (cnt == 8'd0) begin
            keycode <= 8'h00;
            cnt     <= GAP_LOAD;
            state   <= RELEASE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RELEASE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (pop) begin
            keycode <= mem[rd_ptr];
            cnt     <= HOLD_LOAD;
            state   <= PRESS;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          keycode <= 8'h00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
